// File: rtl/reg_xfer_seq.sv
// Register-bus transfer sequencer: drives source output enable and a single destination write pulse.
// Optional capture of the moved byte when XFER_CAPTURE_EN is defined.
module reg_xfer_seq #(
  parameter int IDX_W  = 2,
  parameter int SETTLE = 1,
  parameter int HOLD   = 1,
  localparam int NREG  = 2**IDX_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_src,
  input  logic [IDX_W-1:0] req_dst,
  input  logic             req_ext,
  output logic [NREG-1:0]  n_oe_a,
  output logic             n_oe_ext,
  output logic [NREG-1:0]  w_clk,
  output logic             busy,
  output logic             done
`ifdef XFER_CAPTURE_EN
  ,
  input  logic [7:0]       bus,
  output logic [7:0]       cap_q,
  output logic             cap_valid
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_WRITE, ST_HOLD} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0] src_reg, src_next, dst_reg, dst_next;
  logic             ext_reg, ext_next;
  logic             accept;
  logic [NREG-1:0]  src_dec, dst_dec;
  logic [NREG-1:0]  n_oe_a_next, w_clk_next;
  logic             n_oe_ext_next, busy_next, done_next, req_ready_next;

  generate
    if (SETTLE < 1 || SETTLE > 15 || HOLD < 1 || HOLD > 15) begin : g_bad_param
      $error("reg_xfer_seq: SETTLE and HOLD must be within 1..15");
    end
  endgenerate

  // Decoders work on the post-edge indices so every strobe can be registered.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
      assign src_dec[gi] = (src_next == IDX_W'(gi));
      assign dst_dec[gi] = (dst_next == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    ext_next   = ext_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          src_next   = req_src;
          dst_next   = req_dst;
          ext_next   = req_ext;
          cnt_next   = 4'(SETTLE);
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == 4'd1) state_next = ST_WRITE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_WRITE: begin
        cnt_next   = 4'(HOLD);
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_reg == 4'd1) state_next = ST_IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = ST_IDLE;
    endcase

    // Outputs are derived from the next state so they appear glitch-free from flops.
    n_oe_a_next    = (state_next != ST_IDLE && !ext_next) ? ~src_dec : '1;
    n_oe_ext_next  = !(state_next != ST_IDLE && ext_next);
    w_clk_next     = (state_next == ST_WRITE) ? dst_dec : '0;
    busy_next      = (state_next != ST_IDLE);
    req_ready_next = (state_next == ST_IDLE);
    done_next      = (state_reg == ST_HOLD) && (state_next == ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      src_reg   <= '0;
      dst_reg   <= '0;
      ext_reg   <= 1'b0;
      n_oe_a    <= '1;
      n_oe_ext  <= 1'b1;
      w_clk     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      ext_reg   <= ext_next;
      n_oe_a    <= n_oe_a_next;
      n_oe_ext  <= n_oe_ext_next;
      w_clk     <= w_clk_next;
      busy      <= busy_next;
      done      <= done_next;
      req_ready <= req_ready_next;
    end
  end

`ifdef XFER_CAPTURE_EN
  // Snapshot the bus on the edge that raises the write strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cap_q     <= 8'h00;
      cap_valid <= 1'b0;
    end else if (state_next == ST_WRITE) begin
      cap_q     <= bus;
      cap_valid <= 1'b1;
    end else if (accept) begin
      cap_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Directed self-checking bench for reg_xfer_seq: default timing instance plus a SETTLE=3/HOLD=2 instance.
module tb_reg_xfer_seq;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       req_valid, req_ext, req_ready, busy, done, n_oe_ext;
  logic [1:0] req_src, req_dst;
  logic [3:0] n_oe_a, w_clk;
  logic       req_valid2, req_ext2, req_ready2, busy2, done2, n_oe_ext2;
  logic [1:0] req_src2, req_dst2;
  logic [3:0] n_oe_a2, w_clk2;
`ifdef XFER_CAPTURE_EN
  logic [7:0] bus, cap_q, bus2, cap_q2;
  logic       cap_valid, cap_valid2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_xfer_seq dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_ext(req_ext),
    .n_oe_a(n_oe_a), .n_oe_ext(n_oe_ext), .w_clk(w_clk), .busy(busy), .done(done)
`ifdef XFER_CAPTURE_EN
    , .bus(bus), .cap_q(cap_q), .cap_valid(cap_valid)
`endif
  );

  reg_xfer_seq #(.SETTLE(3), .HOLD(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_src(req_src2), .req_dst(req_dst2), .req_ext(req_ext2),
    .n_oe_a(n_oe_a2), .n_oe_ext(n_oe_ext2), .w_clk(w_clk2), .busy(busy2), .done(done2)
`ifdef XFER_CAPTURE_EN
    , .bus(bus2), .cap_q(cap_q2), .cap_valid(cap_valid2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 when at most one bus driver of the default instance is enabled.
  function automatic logic excl_ok();
    int lows;
    lows = 0;
    for (int i = 0; i < 4; i++) if (!n_oe_a[i]) lows++;
    if (!n_oe_ext) lows++;
    return lows <= 1;
  endfunction

  // Expected strobes for the default instance, cycles 1..5 after a src=1,dst=2 handshake.
  logic [3:0] t2_oe   [0:4] = '{4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1111};
  logic [3:0] t2_wclk [0:4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
  logic       t2_done [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       t2_busy [0:4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  // Back-to-back: 0->1 at cycle 0, 2->3 taken on the done cycle 4; cycles 1..8.
  logic [3:0] t4_oe   [0:7] = '{4'b1110, 4'b1110, 4'b1110, 4'b1111,
                                4'b1011, 4'b1011, 4'b1011, 4'b1111};
  logic [3:0] t4_wclk [0:7] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000,
                                4'b0000, 4'b1000, 4'b0000, 4'b0000};
  logic       t4_done [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int done_seen;
    n_rst = 1'b0;
    req_valid = 1'b0; req_src = '0; req_dst = '0; req_ext = 1'b0;
    req_valid2 = 1'b0; req_src2 = '0; req_dst2 = '0; req_ext2 = 1'b0;
`ifdef XFER_CAPTURE_EN
    bus = 8'h00; bus2 = 8'h00;
`endif

    // Reset held for 3 cycles, released away from the clock edge.
    repeat (3) step();
    chk("rst_oe_a", n_oe_a, 4'b1111);
    @(negedge clk);
    n_rst = 1'b1;
    step();
    chk("rst_oe_a_rel", n_oe_a, 4'b1111);
    chk("rst_oe_ext", n_oe_ext, 1'b1);
    chk("rst_wclk", w_clk, 4'b0000);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef XFER_CAPTURE_EN
    chk("rst_capv", cap_valid, 1'b0);
    chk("rst_capq", cap_q, 8'h00);
`endif

    // Default timing, src=1 dst=2.
    req_valid = 1'b1; req_src = 2'd1; req_dst = 2'd2; req_ext = 1'b0;
`ifdef XFER_CAPTURE_EN
    bus = 8'hA5;
`endif
    chk("t2_ready_c0", req_ready, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) req_valid = 1'b0;
      chk($sformatf("t2_oe_c%0d", k), n_oe_a, t2_oe[k-1]);
      chk($sformatf("t2_wclk_c%0d", k), w_clk, t2_wclk[k-1]);
      chk($sformatf("t2_done_c%0d", k), done, t2_done[k-1]);
      chk($sformatf("t2_busy_c%0d", k), busy, t2_busy[k-1]);
      chk($sformatf("t2_ready_c%0d", k), req_ready, !t2_busy[k-1]);
`ifdef XFER_CAPTURE_EN
      if (k == 3) begin
        chk("t2_capq", cap_q, 8'hA5);
        chk("t2_capv", cap_valid, 1'b1);
      end
`endif
    end
    $display("xfer default src=1 dst=2 checked, failures so far=%0d", failures);

    // SETTLE=3, HOLD=2, external source, dst=3.
    req_valid2 = 1'b1; req_ext2 = 1'b1; req_dst2 = 2'd3; req_src2 = 2'd0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) req_valid2 = 1'b0;
      chk($sformatf("t3_oeext_c%0d", k), n_oe_ext2, !(k >= 1 && k <= 6));
      chk($sformatf("t3_oea_c%0d", k), n_oe_a2, 4'b1111);
      chk($sformatf("t3_wclk_c%0d", k), w_clk2, (k == 4) ? 4'b1000 : 4'b0000);
      chk($sformatf("t3_done_c%0d", k), done2, k == 7);
    end
    $display("xfer settle3/hold2 ext dst=3 checked, failures so far=%0d", failures);

    // Back-to-back with req_valid held high.
    req_valid = 1'b1; req_src = 2'd0; req_dst = 2'd1; req_ext = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin req_src = 2'd2; req_dst = 2'd3; end
      chk($sformatf("t4_oe_c%0d", k), n_oe_a, t4_oe[k-1]);
      chk($sformatf("t4_wclk_c%0d", k), w_clk, t4_wclk[k-1]);
      chk($sformatf("t4_done_c%0d", k), done, t4_done[k-1]);
      chk($sformatf("t4_excl_c%0d", k), excl_ok(), 1'b1);
      if (k == 4) chk("t4_ready_c4", req_ready, 1'b1);
      if (k == 5) begin
        req_valid = 1'b0;
        chk("t4_ready_c5", req_ready, 1'b0);
      end
`ifdef XFER_CAPTURE_EN
      if (k == 1) chk("t4_capv_clr", cap_valid, 1'b0);
`endif
    end
    $display("xfer back-to-back 0->1, 2->3 checked, failures so far=%0d", failures);

    // Reset asserted during WRITE.
    req_valid = 1'b1; req_src = 2'd3; req_dst = 2'd0;
    step();
    req_valid = 1'b0;
    step();
    chk("t5_wclk_write", w_clk, 4'b0001);
    chk("t5_oe_write", n_oe_a, 4'b0111);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t5_wclk_async", w_clk, 4'b0000);
    chk("t5_oe_async", n_oe_a, 4'b1111);
    chk("t5_busy_async", busy, 1'b0);
    chk("t5_ready_async", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done) done_seen++;
      chk($sformatf("t5_idle_oe_%0d", k), n_oe_a, 4'b1111);
    end
    chk("t5_no_done", done_seen, 0);
    chk("t5_busy_after", busy, 1'b0);
    $display("xfer reset-in-write src=3 dst=0 checked, failures so far=%0d", failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
